// File: rtl/cgp_grid_eval.sv
// Runtime-reconfigurable CGP evaluator: LUT4 node grid evaluated one column per clock.
// Define CGP_FITNESS_EN to add exp_data/err_cnt mismatch accumulation.
module cgp_grid_eval #(
    parameter int N_IN   = 4,
    parameter int N_ROWS = 4,
    parameter int N_COLS = 4,
    parameter int N_OUT  = 4,
    localparam int N_NODES = N_ROWS * N_COLS,
    localparam int SEL_W   = $clog2(1 + N_IN + N_NODES),
    localparam int NODE_W  = 16 + 4 * SEL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [NODE_W-1:0] cfg_data,
    output logic              loaded,
    output logic              cfg_err,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   in_data,
`ifdef CGP_FITNESS_EN
    input  logic [N_OUT-1:0]  exp_data,
    output logic [15:0]       err_cnt,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_OUT-1:0]  out_data
);

    localparam int N_SRC   = 1 + N_IN + N_NODES;
    localparam int SRC_PAD = 1 << SEL_W;
    localparam int TOTAL   = N_NODES + N_OUT;
    localparam int PTR_W   = $clog2(TOTAL + 1);
    localparam int COL_W   = $clog2(N_COLS + 1);
    localparam int LIM_W   = SEL_W + 1;
    localparam int ROW_W   = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int IDX_W   = (N_NODES > 1) ? $clog2(N_NODES) : 1;
    localparam int OIDX_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    localparam logic [PTR_W-1:0] TOTAL_P    = PTR_W'(TOTAL);
    localparam logic [PTR_W-1:0] LAST_P     = PTR_W'(TOTAL - 1);
    localparam logic [PTR_W-1:0] NODES_P    = PTR_W'(N_NODES);
    localparam logic [COL_W-1:0] COLS_P     = COL_W'(N_COLS);
    localparam logic [LIM_W-1:0] LIM0_P     = LIM_W'(1 + N_IN);
    localparam logic [LIM_W-1:0] ROWS_LIM_P = LIM_W'(N_ROWS);
    localparam logic [LIM_W-1:0] MAXSEL_P   = LIM_W'(N_SRC - 1);
    localparam logic [ROW_W-1:0] ROW_LAST_P = ROW_W'(N_ROWS - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EVAL, S_DONE} state_t;

    state_t             state_reg, state_next;
    logic [PTR_W-1:0]   ptr_reg, wr_ptr;
    logic [ROW_W-1:0]   ld_row_reg, ld_row_next, wr_row;
    logic [LIM_W-1:0]   ld_limit_reg, ld_limit_next, wr_limit;
    logic               loaded_reg, cfg_err_reg, out_valid_reg;
    logic [N_OUT-1:0]   out_data_reg, out_next;
    logic [N_IN-1:0]    in_reg;
    logic [COL_W-1:0]   col_reg;
    logic [IDX_W-1:0]   col_base;
    logic [N_NODES-1:0] node_val_reg;
    logic [N_ROWS-1:0]  col_out;
    logic [SRC_PAD-1:0] src_bits;
    logic [NODE_W-1:0]  node_mem [N_NODES];
    logic [SEL_W-1:0]   out_sel_mem [N_OUT];
    logic [NODE_W-1:0]  wr_word;
    logic               in_acc, cfg_acc, start_ok, eval_fin, eval_col;
    logic               wr_last, wr_is_node, wr_illegal;

    // Control: handshakes and next state
    always_comb begin
        state_next = state_reg;
        in_ready   = (state_reg == S_IDLE) && loaded_reg;
        cfg_ready  = ((state_reg == S_IDLE) || (state_reg == S_LOAD)) && (ptr_reg < TOTAL_P);
        in_acc     = in_valid && in_ready;
        cfg_acc    = cfg_valid && cfg_ready;
        start_ok   = cfg_start && !in_acc && ((state_reg == S_IDLE) || (state_reg == S_LOAD));
        eval_fin   = (state_reg == S_EVAL) && (col_reg == COLS_P);
        eval_col   = (state_reg == S_EVAL) && (col_reg < COLS_P);
        wr_ptr     = start_ok ? '0 : ptr_reg;
        wr_last    = (wr_ptr == LAST_P);
        case (state_reg)
            S_IDLE, S_LOAD: begin
                if (in_acc)                   state_next = S_EVAL;
                else if (cfg_acc && wr_last)  state_next = S_IDLE;
                else if (start_ok || cfg_acc) state_next = S_LOAD;
            end
            S_EVAL:  if (eval_fin)  state_next = S_DONE;
            S_DONE:  if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Illegal selects are stored as 0 so the evaluator never sees them
    always_comb begin
        wr_limit   = start_ok ? LIM0_P : ld_limit_reg;
        wr_row     = start_ok ? '0 : ld_row_reg;
        wr_is_node = (wr_ptr < NODES_P);
        wr_word    = cfg_data;
        wr_illegal = 1'b0;
        if (wr_is_node) begin
            for (int k = 0; k < 4; k++) begin
                if (LIM_W'(cfg_data[16 + k*SEL_W +: SEL_W]) >= wr_limit) begin
                    wr_word[16 + k*SEL_W +: SEL_W] = '0;
                    wr_illegal = 1'b1;
                end
            end
        end else if (LIM_W'(cfg_data[SEL_W-1:0]) > MAXSEL_P) begin
            wr_word    = '0;
            wr_illegal = 1'b1;
        end
        ld_row_next   = ld_row_reg;
        ld_limit_next = ld_limit_reg;
        if (start_ok) begin
            ld_row_next   = '0;
            ld_limit_next = LIM0_P;
        end
        if (cfg_acc && wr_is_node) begin
            if (wr_row == ROW_LAST_P) begin
                ld_row_next   = '0;
                ld_limit_next = wr_limit + ROWS_LIM_P;
            end else begin
                ld_row_next   = wr_row + 1'b1;
                ld_limit_next = wr_limit;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            ptr_reg       <= '0;
            ld_row_reg    <= '0;
            ld_limit_reg  <= LIM0_P;
            loaded_reg    <= 1'b0;
            cfg_err_reg   <= 1'b0;
            in_reg        <= '0;
            col_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            ld_row_reg   <= ld_row_next;
            ld_limit_reg <= ld_limit_next;
            if (cfg_acc)
                ptr_reg <= wr_ptr + 1'b1;
            else if (start_ok)
                ptr_reg <= '0;
            if (cfg_acc && wr_last)
                loaded_reg <= 1'b1;
            else if (start_ok)
                loaded_reg <= 1'b0;
            cfg_err_reg <= (cfg_err_reg && !start_ok) || (cfg_acc && wr_illegal);
            if (in_acc) begin
                in_reg  <= in_data;
                col_reg <= '0;
            end else if (eval_col) begin
                col_reg <= col_reg + 1'b1;
            end
            if (eval_fin) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= out_next;
            end else if ((state_reg == S_DONE) && out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    // Genome storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NODES; i++) node_mem[i] <= '0;
            for (int i = 0; i < N_OUT; i++) out_sel_mem[i] <= '0;
        end else if (cfg_acc) begin
            if (wr_is_node)
                node_mem[wr_ptr[IDX_W-1:0]] <= wr_word;
            else
                out_sel_mem[OIDX_W'(wr_ptr - NODES_P)] <= wr_word[SEL_W-1:0];
        end
    end

    // Source space: 0 = const 0, then inputs, then nodes column-major
    always_comb begin
        src_bits                  = '0;
        src_bits[N_IN:1]          = in_reg;
        src_bits[N_SRC-1:N_IN+1]  = node_val_reg;
        col_base = eval_col ? IDX_W'(int'(col_reg) * N_ROWS) : '0;
    end

    for (genvar gi = 0; gi < N_ROWS; gi++) begin : g_row
        logic [NODE_W-1:0] word;
        logic [15:0]       lut;
        logic [3:0]        lut_idx;
        assign word = node_mem[col_base + IDX_W'(gi)];
        assign lut  = word[15:0];
        for (genvar gk = 0; gk < 4; gk++) begin : g_pin
            assign lut_idx[gk] = src_bits[word[16 + gk*SEL_W +: SEL_W]];
        end
        assign col_out[gi] = lut[lut_idx];
    end

    for (genvar gi = 0; gi < N_NODES; gi++) begin : g_node
        localparam logic [COL_W-1:0] NODE_COL = COL_W'(gi / N_ROWS);
        logic val_reg;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                val_reg <= 1'b0;
            else if (in_acc)
                val_reg <= 1'b0;
            else if (eval_col && (col_reg == NODE_COL))
                val_reg <= col_out[gi % N_ROWS];
        end
        assign node_val_reg[gi] = val_reg;
    end

    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_out
        assign out_next[gi] = src_bits[out_sel_mem[gi]];
    end

`ifdef CGP_FITNESS_EN
    logic [N_OUT-1:0] exp_reg;
    logic [N_OUT-1:0] diff;
    logic [15:0]      err_cnt_reg;
    logic [16:0]      err_sum;

    always_comb begin
        diff    = out_next ^ exp_reg;
        err_sum = {1'b0, err_cnt_reg} + 17'($countones(diff));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_reg     <= '0;
            err_cnt_reg <= '0;
        end else begin
            if (in_acc)
                exp_reg <= exp_data;
            if (start_ok)
                err_cnt_reg <= '0;
            else if (eval_fin)
                err_cnt_reg <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

    assign err_cnt = err_cnt_reg;
`endif

    assign loaded    = loaded_reg;
    assign cfg_err   = cfg_err_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;

endmodule

// File: tb/tb_cgp_grid_eval.sv
// Self-checking bench for cgp_grid_eval: directed genomes plus random genomes
// compared against a source-array reference model.
module tb_cgp_grid_eval;

    localparam int N_IN    = 4;
    localparam int N_ROWS  = 4;
    localparam int N_COLS  = 4;
    localparam int N_OUT   = 4;
    localparam int N_NODES = N_ROWS * N_COLS;
    localparam int SEL_W   = $clog2(1 + N_IN + N_NODES);
    localparam int NODE_W  = 16 + 4 * SEL_W;
    localparam int N_SRC   = 1 + N_IN + N_NODES;
    localparam int TOTAL   = N_NODES + N_OUT;
    localparam int TMO     = 100;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_start = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [NODE_W-1:0] cfg_data = '0;
    logic              loaded;
    logic              cfg_err;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [N_IN-1:0]   in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [N_OUT-1:0]  out_data;
`ifdef CGP_FITNESS_EN
    logic [N_OUT-1:0]  exp_data = '0;
    logic [15:0]       err_cnt;
`endif

    cgp_grid_eval #(.N_IN(N_IN), .N_ROWS(N_ROWS), .N_COLS(N_COLS), .N_OUT(N_OUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
        .loaded(loaded), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef CGP_FITNESS_EN
        .exp_data(exp_data), .err_cnt(err_cnt),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] m_lut  [N_NODES];
    int          m_sel  [N_NODES][4];
    int          m_osel [N_OUT];
    logic        m_cfg_err;
    int          m_err_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int k = 0; k < N_NODES; k++) begin
            m_lut[k] = '0;
            for (int j = 0; j < 4; j++) m_sel[k][j] = 0;
        end
        for (int o = 0; o < N_OUT; o++) m_osel[o] = 0;
    endtask

    task automatic set_identity();
        clear_model();
        for (int k = 0; k < N_NODES; k++) begin
            m_lut[k]    = 16'hAAAA;
            m_sel[k][0] = (k < N_ROWS) ? 1 + k : 1 + N_IN + k - N_ROWS;
        end
        for (int o = 0; o < N_OUT; o++) m_osel[o] = 1 + N_IN + (N_COLS - 1) * N_ROWS + o;
    endtask

    function automatic int col_limit(input int k);
        return 1 + N_IN + (k / N_ROWS) * N_ROWS;
    endfunction

    // Reference: evaluate nodes in index order, illegal references read as 0
    function automatic logic [N_OUT-1:0] model_eval(input logic [N_IN-1:0] din);
        logic [63:0]      v;
        logic [N_OUT-1:0] r;
        int               idx, s;
        logic [5:0]       sb;
        logic [3:0]       li;
        v = '0;
        for (int i = 0; i < N_IN; i++) if (din[i]) v = v | (64'd1 << (1 + i));
        for (int k = 0; k < N_NODES; k++) begin
            idx = 0;
            for (int j = 0; j < 4; j++) begin
                s  = m_sel[k][j];
                sb = s[5:0];
                if (s < col_limit(k) && v[sb]) idx = idx + (1 << j);
            end
            li = idx[3:0];
            if (m_lut[k][li]) v = v | (64'd1 << (1 + N_IN + k));
        end
        r = '0;
        for (int o = 0; o < N_OUT; o++) begin
            s  = m_osel[o];
            sb = s[5:0];
            if (s < N_SRC && v[sb]) r = r | (N_OUT'(1) << o);
        end
        return r;
    endfunction

    task automatic load_genome();
        logic [NODE_W-1:0] w;
        int waited;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        m_cfg_err = 1'b0;
        m_err_cnt = 0;
        check("start_clr_loaded", loaded, 0);
        for (int k = 0; k < TOTAL; k++) begin
            w = '0;
            if (k < N_NODES) begin
                w[15:0] = m_lut[k];
                for (int j = 0; j < 4; j++) begin
                    w[16 + j*SEL_W +: SEL_W] = SEL_W'(m_sel[k][j]);
                    if (m_sel[k][j] >= col_limit(k)) m_cfg_err = 1'b1;
                end
            end else begin
                w[SEL_W-1:0] = SEL_W'(m_osel[k - N_NODES]);
                if (m_osel[k - N_NODES] >= N_SRC) m_cfg_err = 1'b1;
            end
            cfg_valid = 1'b1;
            cfg_data  = w;
            waited = 0;
            while (!cfg_ready && waited < TMO) begin
                tick();
                waited++;
            end
            check("cfg_ready_wait", cfg_ready, 1);
            tick();
            check("cfg_err_word", cfg_err, m_cfg_err);
        end
        cfg_valid = 1'b0;
        check("loaded_after_last", loaded, 1);
        check("cfg_ready_full", cfg_ready, 0);
    endtask

    function automatic int sat16(input int x);
        return (x > 65535) ? 65535 : x;
    endfunction

    task automatic do_eval(input logic [N_IN-1:0] din, input logic [N_OUT-1:0] dexp,
                           output logic [N_OUT-1:0] got);
        logic [N_OUT-1:0] want;
        int waited, lat;
        want     = model_eval(din);
        in_valid = 1'b1;
        in_data  = din;
`ifdef CGP_FITNESS_EN
        exp_data = dexp;
`endif
        waited = 0;
        while (!in_ready && waited < TMO) begin
            tick();
            waited++;
        end
        check("in_ready_wait", in_ready, 1);
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < TMO) begin
            tick();
            lat++;
        end
        check("latency", lat, N_COLS + 1);
        check("out_data", out_data, want);
        got = out_data;
        m_err_cnt = sat16(m_err_cnt + $countones(want ^ dexp));
`ifdef CGP_FITNESS_EN
        check("err_cnt", err_cnt, m_err_cnt);
`endif
        $display("eval in=%b exp=%b out=%b model=%b lat=%0d", din, dexp, got, want, lat);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_valid_clr", out_valid, 0);
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < TMO) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        logic [N_OUT-1:0] got;
        int waited, lat, lim;

        // Reset values
        clear_model();
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_loaded", loaded, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        tick();

        // Identity genome
        set_identity();
        load_genome();
        do_eval(4'b1011, 4'b0000, got);
        check("identity_1011", got, 4'b1011);

        // Reset while evaluating
        in_valid = 1'b1;
        in_data  = 4'b0101;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_loaded", loaded, 0);
        check("mid_rst_cfg_ready", cfg_ready, 1);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_cfg_err", cfg_err, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", in_ready, 0);
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_loaded", loaded, 0);

        // XOR sweep
        clear_model();
        m_lut[0]    = 16'h6666;
        m_sel[0][0] = 1;
        m_sel[0][1] = 2;
        m_osel[0]   = 1 + N_IN;
        load_genome();
        check("xor_cfg_err", cfg_err, 0);
        for (int i = 0; i < 4; i++) begin
            do_eval(N_IN'(i), 4'b0000, got);
            check("xor_bit0", got[0], (i ^ (i >> 1)) & 1);
        end

        // Self-referencing select
        clear_model();
        m_lut[0]    = 16'hAAAB;
        m_sel[0][0] = 1 + N_IN;
        m_osel[0]   = 1 + N_IN;
        load_genome();
        check("illegal_cfg_err", cfg_err, 1);
        do_eval(4'b1111, 4'b0000, got);
        check("illegal_lut0", got[0], 1);

        // Backpressure on the result
        set_identity();
        load_genome();
        in_valid = 1'b1;
        in_data  = 4'b0110;
`ifdef CGP_FITNESS_EN
        exp_data = 4'b0000;
`endif
        waited = 0;
        while (!in_ready && waited < TMO) begin
            tick();
            waited++;
        end
        check("bp_in_ready_a", in_ready, 1);
        tick();
        in_data = 4'b1001;
        wait_result(lat);
        check("bp_latency_a", lat, N_COLS + 1);
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_data", out_data, 4'b0110);
            check("bp_hold_in_ready", in_ready, 0);
            check("bp_hold_valid", out_valid, 1);
            tick();
        end
        $display("backpressure first result %b held", out_data);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_consumed", out_valid, 0);
        check("bp_idle_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        wait_result(lat);
        check("bp_latency_b", lat, N_COLS + 1);
        check("bp_second", out_data, 4'b1001);
        m_err_cnt = sat16(m_err_cnt + 4);
`ifdef CGP_FITNESS_EN
        check("bp_err_cnt", err_cnt, m_err_cnt);
`endif
        $display("backpressure second result %b", out_data);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

`ifdef CGP_FITNESS_EN
        // Fitness accumulation
        set_identity();
        load_genome();
        check("fit_err_cnt_0", err_cnt, 0);
        do_eval(4'b1011, 4'b0011, got);
        check("fit_err_cnt_1", err_cnt, 1);
        do_eval(4'b1011, 4'b0011, got);
        check("fit_err_cnt_2", err_cnt, 2);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        m_err_cnt = 0;
        check("fit_err_cnt_clr", err_cnt, 0);
`endif

        // Random genomes, mostly legal with occasional illegal selects
        for (int g = 0; g < 12; g++) begin
            for (int k = 0; k < N_NODES; k++) begin
                m_lut[k] = 16'($urandom);
                lim = col_limit(k);
                for (int j = 0; j < 4; j++) begin
                    if ($urandom_range(0, 9) == 0)
                        m_sel[k][j] = int'($urandom_range(0, (1 << SEL_W) - 1));
                    else
                        m_sel[k][j] = int'($urandom_range(0, lim - 1));
                end
            end
            for (int o = 0; o < N_OUT; o++) begin
                if ($urandom_range(0, 9) == 0)
                    m_osel[o] = int'($urandom_range(0, (1 << SEL_W) - 1));
                else
                    m_osel[o] = int'($urandom_range(0, N_SRC - 1));
            end
            load_genome();
            for (int e = 0; e < 6; e++) begin
                do_eval(N_IN'($urandom), N_OUT'($urandom), got);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cgp_grid_eval.md
Name: cgp_grid_eval

Overview:
- Runtime-reconfigurable Cartesian Genetic Programming (CGP) evaluator.
- Generalises the fixed, hard-wired LUT4 grid: the rows×columns geometry, input count and output count are parameters.
- The genome (per-node LUT truth tables, input selects, output selects) is loaded over a stream port. The evolution host can swap candidates without resynthesis.
- Evaluation is column-sequential: one column per clock. Results are returned over a valid/ready handshake.

Parameters:
- N_IN, 4, primary input count.
- N_ROWS, 4, nodes per column.
- N_COLS, 4, columns.
- N_OUT, 4, primary output count.
- Derived localparam N_NODES = N_ROWS*N_COLS.
- Derived localparam SEL_W = clog2(1+N_IN+N_NODES).
- Derived localparam NODE_W = 16+4*SEL_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_start  in  1  pulse: clear write pointer, clear loaded and cfg_err, begin genome load.
- cfg_valid  in  1  genome word valid.
- cfg_ready  out  1  genome word accepted when cfg_valid&cfg_ready.
- cfg_data  in  NODE_W  genome word. Node word = {sel3,sel2,sel1,sel0,lut_init[15:0]}. Output word uses bits [SEL_W-1:0] only.
- loaded  out  1  full genome present.
- cfg_err  out  1  sticky: an illegal select was written.
- in_valid  in  1  evaluation request.
- in_ready  out  1  request accepted when in_valid&in_ready.
- in_data  in  N_IN  primary input vector.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed.
- out_data  out  N_OUT  result vector.

Behaviour:
- Source index space:
  - 0 = constant 0.
  - 1..N_IN = in_data[i-1].
  - Node (c,r) = 1+N_IN+c*N_ROWS+r, column-major.
- Node output:
  - O = lut_init[{I3,I2,I1,I0}], where Ik = value at source selk.
  - A node in column c may only reference constant 0, inputs, or nodes in columns < c.
  - An output gene may reference any source.
  - An illegal select (same/later column, or index > max) evaluates as constant 0 and sets cfg_err at the write cycle.
- Load order: N_NODES node words (node 0..N_NODES-1), then N_OUT output words. Total N_NODES+N_OUT words.
- cfg_ready:
  - High in IDLE or LOAD while pointer < N_NODES+N_OUT.
  - Low in EVAL, in DONE, and after the last word.
- loaded rises the cycle after the last word is written.
- cfg_start in EVAL/DONE is ignored.
- States:
  - IDLE: in_ready=loaded. On accept, capture in_data, clear node registers, col=0, go to EVAL. On cfg_start, go to LOAD.
  - LOAD: accept words. After the last word, go to IDLE with loaded=1. cfg_start restarts the pointer at 0.
  - EVAL: each cycle, register all N_ROWS nodes of column col, then col++. After col=N_COLS-1 is written, register out_data from the output selects and set out_valid, go to DONE.
  - DONE: hold out_data and out_valid until out_ready. On handshake, out_valid=0 and go to IDLE.
- Latency: accept at edge T. Columns are written at T+1..T+N_COLS. out_valid is high after edge T+N_COLS+1 (5 cycles at defaults).
- in_ready=0 outside IDLE. One evaluation is in flight at a time.
- Reset values:
  - State IDLE.
  - out_valid=0, out_data=0.
  - loaded=0, cfg_err=0.
  - Genome storage all zeros.
  - cfg_ready=1, in_ready=0.
- Reset mid-load or mid-eval aborts immediately. The genome is cleared and must be reloaded.
- Node selects may repeat a source (e.g. I1=I2=same wire); this is legal.

Optional Feature:
- CGP_FITNESS_EN
- Defined:
  - Adds input port exp_data (N_OUT), captured with in_data.
  - Adds output err_cnt (16 bits), reset 0. At the DONE entry edge, err_cnt += popcount(out_data ^ exp_data), saturating at 16'hFFFF.
  - cfg_start clears err_cnt.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset check: assert rst_n=0 mid-EVAL, then release -> out_valid=0, loaded=0, cfg_ready=1, in_ready=0, cfg_err=0.
- Identity genome (defaults, SEL_W=5):
  - Column 0: node(0,r) lut=16'hAAAA, sel0=1+r.
  - Columns 1..3: select node(c-1,r).
  - Outputs select node(3,r).
  - in_data=4'b1011 -> out_data=4'b1011 with out_valid exactly 5 cycles after accept.
- XOR sweep: node(0,0) lut=16'h6666, sel0=1, sel1=2; output0 selects node(0,0). Apply in_data 0,1,2,3 -> out_data[0] = 0,1,1,0.
- Illegal select: node(0,0) sel0=5 (self) -> cfg_err=1 the cycle after the write. Output equals lut_init[0] for I0=0.
- Backpressure: hold out_ready=0 for 3 cycles -> out_data stable, in_ready=0, a second in_valid is not accepted. The first result is consumed on out_ready=1, then the second request is accepted.
- Fitness (CGP_FITNESS_EN): identity genome; in_data=4'b1011 with exp_data=4'b0011, twice -> err_cnt=1, then 2. cfg_start -> err_cnt=0.
